// File: rtl/rns_reg_file_sb.sv
// Dual-bank (binary / RNS) register file with write-to-read bypass, a per-entry
// busy scoreboard and a handshaked bank-dump sequencer.
module rns_reg_file_sb #(
  parameter int NUM_DOMAINS = 1,
  parameter int NUM_REGS    = 8,
  localparam int W  = NUM_DOMAINS * 8,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic          wr_bank,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW:0]   rd_addr1,
  input  logic [AW:0]   rd_addr2,
  input  logic [AW-1:0] rd_addr3,
  output logic [W-1:0]  rd_data1,
  output logic [W-1:0]  rd_data2,
  output logic [W-1:0]  rd_data3,
  output logic          busy1,
  output logic          busy2,
  input  logic          rsv_en,
  input  logic          rsv_bank,
  input  logic [AW-1:0] rsv_addr,
  input  logic          dump_start,
  input  logic          dump_bank,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic [AW-1:0] dump_addr,
  output logic [W-1:0]  dump_data,
  output logic          dump_busy,
  output logic          dump_done,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  logic [7:0]          bin_q [NUM_REGS];
  logic [W-1:0]        rns_q [NUM_REGS];
  logic [NUM_REGS-1:0] bsy_bin_q, bsy_bin_d;
  logic [NUM_REGS-1:0] bsy_rns_q, bsy_rns_d;
  state_t              state_q, state_d;
  logic [AW-1:0]       ptr_q, ptr_d;
  logic                bank_q, bank_d;

  function automatic logic wr_hit(input logic bank, input logic [AW-1:0] idx);
    return wr_en && (wr_bank == bank) && (wr_addr == idx);
  endfunction

  // Read with bypass: a same-cycle write to the addressed entry wins over storage.
  function automatic logic [W-1:0] rd_entry(input logic bank, input logic [AW-1:0] idx);
    logic [W-1:0] v;
    v = '0;
    if (wr_hit(bank, idx)) begin
      if (bank) v = wr_data;
      else      v[7:0] = wr_data[7:0];
    end else if (bank) begin
      v = rns_q[idx];
    end else begin
      v[7:0] = bin_q[idx];
    end
    return v;
  endfunction

  function automatic logic rd_busy(input logic bank, input logic [AW-1:0] idx);
    logic f;
    f = bank ? bsy_rns_q[idx] : bsy_bin_q[idx];
    return f && !wr_hit(bank, idx);
  endfunction

  always_comb begin
    rd_data1 = rd_entry(rd_addr1[AW], rd_addr1[AW-1:0]);
    rd_data2 = rd_entry(rd_addr2[AW], rd_addr2[AW-1:0]);
    rd_data3 = rd_entry(1'b0, rd_addr3);
    busy1    = rd_busy(rd_addr1[AW], rd_addr1[AW-1:0]);
    busy2    = rd_busy(rd_addr2[AW], rd_addr2[AW-1:0]);
  end

  // Reservation is applied after the write-back clear so a new reservation wins.
  always_comb begin
    bsy_bin_d = bsy_bin_q;
    bsy_rns_d = bsy_rns_q;
    if (wr_en) begin
      if (wr_bank) bsy_rns_d[wr_addr] = 1'b0;
      else         bsy_bin_d[wr_addr] = 1'b0;
    end
    if (rsv_en) begin
      if (rsv_bank) bsy_rns_d[rsv_addr] = 1'b1;
      else          bsy_bin_d[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        bin_q[i] <= '0;
        rns_q[i] <= '0;
      end
      bsy_bin_q <= '0;
      bsy_rns_q <= '0;
    end else begin
      if (wr_en) begin
        if (wr_bank) rns_q[wr_addr] <= wr_data;
        else         bin_q[wr_addr] <= wr_data[7:0];
      end
      bsy_bin_q <= bsy_bin_d;
      bsy_rns_q <= bsy_rns_d;
    end
  end

  // Dump handshake: a beat transfers on a rising edge where dump_valid and
  // dump_ready are both high; dump_valid stays high with stable address until then.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    bank_d     = bank_q;
    dump_valid = 1'b0;
    dump_done  = 1'b0;
    dump_busy  = 1'b0;
    case (state_q)
      IDLE: begin
        if (dump_start) begin
          bank_d  = dump_bank;
          ptr_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        dump_valid = 1'b1;
        dump_busy  = 1'b1;
        if (dump_ready) begin
          if (ptr_q == AW'(NUM_REGS - 1)) state_d = DONE;
          else                            ptr_d   = ptr_q + AW'(1);
        end
      end
      DONE: begin
        dump_done = 1'b1;
        dump_busy = 1'b1;
        ptr_d     = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      bank_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      bank_q  <= bank_d;
    end
  end

  assign dump_addr = ptr_q;
  assign dump_data = rd_entry(bank_q, ptr_q);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rns_reg_file_sb.sv
// Bench for rns_reg_file_sb: directed vector table, randomized reads/writes
// against an array model, and hand-written dump sequences.
module tb_rns_reg_file_sb;

  localparam int ND = 2;
  localparam int NR = 8;
  localparam int W  = ND * 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en, wr_bank, rsv_en, rsv_bank, dump_start, dump_bank, dump_ready;
  logic [AW-1:0] wr_addr, rd_addr3, rsv_addr;
  logic [W-1:0]  wr_data;
  logic [AW:0]   rd_addr1, rd_addr2;
  logic [W-1:0]  rd_data1, rd_data2, rd_data3, dump_data;
  logic          busy1, busy2, dump_valid, dump_busy, dump_done;
  logic [AW-1:0] dump_addr;
  logic [1:0]    dbg_state;

  int checks = 0;
  int failures = 0;

  logic [7:0]   bin_m [NR];
  logic [W-1:0] rns_m [NR];
  logic         busy_m [2][NR];
  logic [W-1:0] exp_q [$];

  rns_reg_file_sb #(.NUM_DOMAINS(ND), .NUM_REGS(NR)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_addr3(rd_addr3),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_data3(rd_data3),
    .busy1(busy1), .busy2(busy2),
    .rsv_en(rsv_en), .rsv_bank(rsv_bank), .rsv_addr(rsv_addr),
    .dump_start(dump_start), .dump_bank(dump_bank), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data),
    .dump_busy(dump_busy), .dump_done(dump_done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic          wb;
    logic [AW-1:0] wa;
    logic [W-1:0]  wd;
    logic [AW:0]   r1;
    logic [AW:0]   r2;
    logic [AW-1:0] r3;
    logic          rs;
    logic          rb;
    logic [AW-1:0] ra;
    logic [W-1:0]  e1;
    logic [W-1:0]  e2;
    logic [W-1:0]  e3;
    logic          eb1;
    logic          eb2;
  } vec_t;

  vec_t vt [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: entry contents plus current-cycle write forwarding.
  function automatic logic [W-1:0] m_read(input logic bank, input logic [AW-1:0] idx);
    if (wr_en && wr_bank == bank && wr_addr == idx)
      return bank ? wr_data : {8'h00, wr_data[7:0]};
    return bank ? rns_m[idx] : {8'h00, bin_m[idx]};
  endfunction

  function automatic logic m_busy(input logic bank, input logic [AW-1:0] idx);
    if (wr_en && wr_bank == bank && wr_addr == idx) return 1'b0;
    return busy_m[bank][idx];
  endfunction

  task automatic m_clear();
    for (int i = 0; i < NR; i++) begin
      bin_m[i] = '0;
      rns_m[i] = '0;
      busy_m[0][i] = 1'b0;
      busy_m[1][i] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      if (wr_en) begin
        if (wr_bank) rns_m[wr_addr] = wr_data;
        else         bin_m[wr_addr] = wr_data[7:0];
        busy_m[wr_bank][wr_addr] = 1'b0;
      end
      if (rsv_en) busy_m[rsv_bank][rsv_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_bank = 0; wr_addr = '0; wr_data = '0;
    rd_addr1 = '0; rd_addr2 = '0; rd_addr3 = '0;
    rsv_en = 0; rsv_bank = 0; rsv_addr = '0;
    dump_start = 0; dump_bank = 0; dump_ready = 0;
  endtask

  initial begin
    int b;
    int k;
    idle_inputs();
    reset = 1'b0;
    m_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dump_valid", 32'(dump_valid), 0);
    chk("rst_dump_busy", 32'(dump_busy), 0);
    chk("rst_dump_done", 32'(dump_done), 0);
    chk("rst_dump_addr", 32'(dump_addr), 0);
    reset = 1'b1;

    for (int a = 0; a < 2 * NR; a++) begin
      rd_addr1 = 4'(a);
      rd_addr2 = 4'(15 - a);
      rd_addr3 = 3'(a);
      #1;
      chk("rst_rd1", 32'(rd_data1), 0);
      chk("rst_rd2", 32'(rd_data2), 0);
      chk("rst_rd3", 32'(rd_data3), 0);
      chk("rst_busy1", 32'(busy1), 0);
      chk("rst_busy2", 32'(busy2), 0);
    end

    //       we wb wa  wd        r1     r2     r3 rs rb ra  e1        e2        e3        b1 b2
    vt[0]  = '{0, 0, 0, 16'h0000, 4'hB, 4'h3, 3, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0};
    vt[1]  = '{1, 1, 3, 16'h1234, 4'hB, 4'h3, 3, 0, 0, 0, 16'h1234, 16'h0000, 16'h0000, 0, 0};
    vt[2]  = '{0, 0, 0, 16'h0000, 4'hB, 4'h3, 3, 0, 0, 0, 16'h1234, 16'h0000, 16'h0000, 0, 0};
    vt[3]  = '{1, 0, 5, 16'hBEA7, 4'h5, 4'hD, 5, 0, 0, 0, 16'h00A7, 16'h0000, 16'h00A7, 0, 0};
    vt[4]  = '{0, 0, 0, 16'h0000, 4'h5, 4'h3, 5, 0, 0, 0, 16'h00A7, 16'h0000, 16'h00A7, 0, 0};
    vt[5]  = '{0, 0, 0, 16'h0000, 4'hA, 4'hB, 3, 1, 1, 2, 16'h0000, 16'h1234, 16'h0000, 0, 0};
    vt[6]  = '{0, 0, 0, 16'h0000, 4'hA, 4'hB, 3, 0, 0, 0, 16'h0000, 16'h1234, 16'h0000, 1, 0};
    vt[7]  = '{1, 1, 2, 16'h5555, 4'hA, 4'hA, 2, 0, 0, 0, 16'h5555, 16'h5555, 16'h0000, 0, 0};
    vt[8]  = '{0, 0, 0, 16'h0000, 4'hA, 4'h5, 5, 0, 0, 0, 16'h5555, 16'h00A7, 16'h00A7, 0, 0};
    vt[9]  = '{1, 1, 4, 16'h0404, 4'hC, 4'h4, 4, 1, 1, 4, 16'h0404, 16'h0000, 16'h0000, 0, 0};
    vt[10] = '{0, 0, 0, 16'h0000, 4'hC, 4'h4, 4, 0, 0, 0, 16'h0404, 16'h0000, 16'h0000, 1, 0};
    vt[11] = '{0, 0, 0, 16'h0000, 4'hC, 4'h4, 4, 1, 0, 4, 16'h0404, 16'h0000, 16'h0000, 1, 0};
    vt[12] = '{0, 0, 0, 16'h0000, 4'hC, 4'h4, 4, 0, 0, 0, 16'h0404, 16'h0000, 16'h0000, 1, 1};
    vt[13] = '{1, 0, 4, 16'hFF77, 4'hC, 4'h4, 4, 0, 0, 0, 16'h0404, 16'h0077, 16'h0077, 1, 0};
    vt[14] = '{0, 0, 0, 16'h0000, 4'hC, 4'h4, 4, 0, 0, 0, 16'h0404, 16'h0077, 16'h0077, 1, 0};

    for (int i = 0; i < 15; i++) begin
      wr_en = vt[i].we; wr_bank = vt[i].wb; wr_addr = vt[i].wa; wr_data = vt[i].wd;
      rd_addr1 = vt[i].r1; rd_addr2 = vt[i].r2; rd_addr3 = vt[i].r3;
      rsv_en = vt[i].rs; rsv_bank = vt[i].rb; rsv_addr = vt[i].ra;
      #1;
      chk($sformatf("vec%0d_rd1", i), 32'(rd_data1), 32'(vt[i].e1));
      chk($sformatf("vec%0d_rd2", i), 32'(rd_data2), 32'(vt[i].e2));
      chk($sformatf("vec%0d_rd3", i), 32'(rd_data3), 32'(vt[i].e3));
      chk($sformatf("vec%0d_busy1", i), 32'(busy1), 32'(vt[i].eb1));
      chk($sformatf("vec%0d_busy2", i), 32'(busy2), 32'(vt[i].eb2));
      tick();
    end

    for (int i = 0; i < 300; i++) begin
      wr_en    = 1'($urandom_range(0, 1));
      wr_bank  = 1'($urandom_range(0, 1));
      wr_addr  = 3'($urandom_range(0, NR - 1));
      wr_data  = 16'($urandom);
      rsv_en   = 1'($urandom_range(0, 1));
      rsv_bank = 1'($urandom_range(0, 1));
      rsv_addr = 3'($urandom_range(0, NR - 1));
      rd_addr1 = 4'($urandom_range(0, 15));
      rd_addr2 = (i % 4 == 0) ? {wr_bank, wr_addr} : 4'($urandom_range(0, 15));
      rd_addr3 = 3'($urandom_range(0, NR - 1));
      #1;
      chk("rand_rd1", 32'(rd_data1), 32'(m_read(rd_addr1[AW], rd_addr1[AW-1:0])));
      chk("rand_rd2", 32'(rd_data2), 32'(m_read(rd_addr2[AW], rd_addr2[AW-1:0])));
      chk("rand_rd3", 32'(rd_data3), 32'(m_read(1'b0, rd_addr3)));
      chk("rand_busy1", 32'(busy1), 32'(m_busy(rd_addr1[AW], rd_addr1[AW-1:0])));
      chk("rand_busy2", 32'(busy2), 32'(m_busy(rd_addr2[AW], rd_addr2[AW-1:0])));
      tick();
    end
    idle_inputs();

    // Binary-bank dump with a consumer that is always ready.
    for (int i = 0; i < NR; i++) begin
      wr_en = 1; wr_bank = 0; wr_addr = 3'(i); wr_data = 16'(i + 1);
      exp_q.push_back(16'(i + 1));
      tick();
    end
    wr_en = 0;
    #1;
    chk("dumpa_idle_valid", 32'(dump_valid), 0);
    dump_start = 1; dump_bank = 0; dump_ready = 1;
    tick();
    dump_start = 0;
    for (int i = 0; i < NR; i++) begin
      #1;
      chk("dumpa_valid", 32'(dump_valid), 1);
      chk("dumpa_addr", 32'(dump_addr), 32'(i));
      chk("dumpa_data", 32'(dump_data), 32'(exp_q.pop_front()));
      chk("dumpa_busy", 32'(dump_busy), 1);
      chk("dumpa_done_early", 32'(dump_done), 0);
      tick();
    end
    chk("dumpa_done", 32'(dump_done), 1);
    chk("dumpa_done_valid", 32'(dump_valid), 0);
    chk("dumpa_done_busy", 32'(dump_busy), 1);
    tick();
    chk("dumpa_done_once", 32'(dump_done), 0);
    chk("dumpa_after_busy", 32'(dump_busy), 0);

    // RNS-bank dump with stalls, a write to the stalled entry and an ignored restart.
    for (int i = 0; i < NR; i++) begin
      wr_en = 1; wr_bank = 1; wr_addr = 3'(i); wr_data = 16'($urandom);
      tick();
    end
    wr_en = 0;
    dump_start = 1; dump_bank = 1;
    tick();
    b = 0;
    k = 0;
    while (b < NR && k < 200) begin
      dump_ready = (k % 3 == 0);
      wr_en = 0; dump_start = 0;
      if (k == 4) begin
        wr_en = 1; wr_bank = 1; wr_addr = 3'(b); wr_data = 16'hC0DE;
      end
      if (k == 5) begin
        dump_start = 1; dump_bank = 0;
      end
      #1;
      chk("dumpb_valid", 32'(dump_valid), 1);
      chk("dumpb_addr", 32'(dump_addr), 32'(b));
      chk("dumpb_data", 32'(dump_data), 32'(m_read(1'b1, 3'(b))));
      chk("dumpb_done_early", 32'(dump_done), 0);
      if (dump_ready) b++;
      tick();
      k++;
    end
    wr_en = 0; dump_start = 0;
    chk("dumpb_beats", 32'(b), NR);
    chk("dumpb_stored_write", 32'(rns_m[2]), 32'h0000C0DE);
    chk("dumpb_done", 32'(dump_done), 1);
    tick();
    chk("dumpb_after_busy", 32'(dump_busy), 0);
    chk("dumpb_after_valid", 32'(dump_valid), 0);

    // Reset while the fourth beat is presented aborts the dump.
    dump_start = 1; dump_bank = 0; dump_ready = 1;
    tick();
    dump_start = 0;
    repeat (3) tick();
    chk("dumpc_pre_addr", 32'(dump_addr), 3);
    chk("dumpc_pre_valid", 32'(dump_valid), 1);
    #1;
    reset = 1'b0;
    #1;
    m_clear();
    chk("dumpc_valid", 32'(dump_valid), 0);
    chk("dumpc_busy", 32'(dump_busy), 0);
    chk("dumpc_done", 32'(dump_done), 0);
    chk("dumpc_addr", 32'(dump_addr), 0);
    for (int a = 0; a < NR; a++) begin
      rd_addr1 = {1'b0, 3'(a)};
      rd_addr2 = {1'b1, 3'(a)};
      rd_addr3 = 3'(a);
      #1;
      chk("dumpc_rd1", 32'(rd_data1), 0);
      chk("dumpc_rd2", 32'(rd_data2), 0);
      chk("dumpc_rd3", 32'(rd_data3), 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("dumpc_no_done", 32'(dump_done), 0);
      chk("dumpc_idle_busy", 32'(dump_busy), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rns_reg_file_sb.md
Name: rns_reg_file_sb

Overview:
- Parametrised next-generation register file for the 8-bit RISC/RNS datapath.
- Holds two banks: a binary bank (8-bit entries) and an RNS bank (NUM_DOMAINS*8-bit entries), both of configurable depth.
- Adds three things: write-to-read bypass, a per-entry busy scoreboard for hazard detection, and a handshaked dump sequencer.
- The dump sequencer streams a whole bank out for context save / RSTORE sequences.

Parameters:
- NUM_DOMAINS, 1, number of 8-bit RNS residue domains per RNS entry; W = NUM_DOMAINS*8.
- NUM_REGS, 8, entries per bank; power of 2, at least 2. AW = log2(NUM_REGS) is a derived localparam.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  write enable.
- wr_bank  in  1  write bank select: 0 = binary bank, 1 = RNS bank.
- wr_addr  in  AW  write entry index.
- wr_data  in  W  write data; the binary bank takes wr_data[7:0].
- rd_addr1  in  AW+1  read port 1 address; MSB = bank (1 = RNS), lower AW bits = index.
- rd_addr2  in  AW+1  read port 2 address, same format as rd_addr1.
- rd_addr3  in  AW  read port 3 index; binary bank only (RSTORE path).
- rd_data1  out  W  read port 1 data.
- rd_data2  out  W  read port 2 data.
- rd_data3  out  W  read port 3 data.
- busy1  out  1  scoreboard busy flag of the entry addressed by rd_addr1.
- busy2  out  1  scoreboard busy flag of the entry addressed by rd_addr2.
- rsv_en  in  1  reserve an entry (marks a pending write-back).
- rsv_bank  in  1  bank of the entry to reserve.
- rsv_addr  in  AW  index of the entry to reserve.
- dump_start  in  1  request a dump of the bank given by dump_bank.
- dump_bank  in  1  bank to dump; sampled with dump_start.
- dump_valid  out  1  dump_data / dump_addr are valid.
- dump_ready  in  1  consumer accepts the current dump beat.
- dump_addr  out  AW  index of the entry currently presented.
- dump_data  out  W  data of the entry currently presented.
- dump_busy  out  1  sequencer is not idle.
- dump_done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (reset = 0, asynchronous):
  - All entries in both banks = 0; all busy flags = 0.
  - FSM = IDLE, dump pointer = 0, latched bank = 0.
  - dump_valid = 0, dump_busy = 0, dump_done = 0, dump_addr = 0.
  - rd_data*/busy* follow their combinational definitions over the cleared state (all 0).
- Reset asserted mid-dump aborts the dump; no dump_done pulse is produced.
- Write: on the rising edge with wr_en = 1, the entry (wr_bank, wr_addr) takes the write data.
  - Binary bank stores wr_data[7:0].
  - RNS bank stores the full W bits.
- Reads: combinational, zero latency.
  - Binary-bank reads are zero-extended to W bits.
- Bypass: if wr_en = 1 and the write's bank and index match a read port's bank and index, that port returns the incoming wr_data this cycle.
  - A binary-bank bypass returns the zero-extended wr_data[7:0].
  - Applies to rd_data1, rd_data2, rd_data3 and dump_data.
- Scoreboard: one busy flag per entry per bank.
  - rsv_en sets the flag at the clock edge.
  - wr_en to the same entry clears it at the clock edge.
  - rsv_en and wr_en to the same entry in the same cycle: the flag ends set (the new reservation wins).
  - busyN = flag of the addressed entry AND NOT (wr_en to that same entry this cycle), i.e. the flag is bypassed consistently with the data.
- Dump FSM, states IDLE, STREAM, DONE:
  - IDLE: when dump_start = 1, latch dump_bank, pointer = 0, and enter STREAM on the next edge. Otherwise stay in IDLE.
  - STREAM: dump_valid = 1. dump_addr = pointer. dump_data = entry (latched bank, pointer), with bypass.
    - When dump_valid and dump_ready are both 1, the beat transfers.
    - If pointer = NUM_REGS-1, go to DONE; otherwise pointer increments.
    - dump_valid never drops without a transfer.
  - DONE: dump_done = 1 for exactly one cycle, dump_valid = 0, then return to IDLE.
  - dump_busy = 1 in STREAM and DONE.
  - dump_start is ignored outside IDLE.
- Writes and reservations remain legal during a dump.
  - A write to the presented entry before its handshake changes dump_data in that same cycle.
  - Entries already transferred are not re-sent.
- The dump reads the binary bank zero-extended and does not alter busy flags.
- NUM_REGS boundary: the pointer wraps to 0 only through IDLE; there is no modular overflow inside STREAM.

Test Plan:
- Reset then read all addresses on all ports -> rd_data* = 0 and busy* = 0. Write RNS[3] = 0x1234 with NUM_DOMAINS = 2, then read rd_addr1 = {1,3} -> 0x1234. Read rd_addr2 = {0,3} -> 0x0000.
- Write binary[5] = 0xA7 while rd_addr1 = {0,5} and rd_addr3 = 5 in the same cycle -> both ports return 0x00A7 that cycle (bypass). The ports still return 0x00A7 after the edge.
- rsv_en RNS[2] -> busy1 = 1 for rd_addr1 = {1,2}. Next, wr_en RNS[2] -> busy1 = 0 in the write cycle and after it. Simultaneous rsv_en and wr_en to RNS[4] -> flag set after the edge.
- Preload binary[i] = i+1 for i = 0..7, dump_start with bank 0, dump_ready always 1 -> 8 consecutive beats with addr 0..7 and data 1..8, then one dump_done pulse; dump_busy = 0 afterward.
- Dump of the RNS bank with dump_ready toggled 1,0,0,1,… -> dump_valid stays high and data stays stable while stalled. A write to the stalled entry updates dump_data. A second dump_start during STREAM is ignored.
- Assert reset during STREAM at beat 3 -> dump_valid = 0 immediately, no dump_done pulse, and all entries read 0.
